// File: rtl/memory_32_4_ram_pkg.sv
// Shared types for the 32-bit x 16-word tap memory leaf and its wrappers.
// Field order of mem_int is fixed; wrapper aliases must stay layout-identical.
package memory_32_4_ram_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DEPTH  = 2 ** ADDR_W;

   typedef struct packed {
      logic [ADDR_W-1:0] rd_address;
      logic              rd_vld;
      logic [ADDR_W-1:0] wr_address;
      logic              wr_vld;
   } mem_int;

   typedef mem_int mem_int_32_4;

endpackage

// File: rtl/memory_32_4_ram.sv
// 16 x 32 simple dual-port RAM: one write port, one registered read port (read-first).
// Array contents are never cleared so taps preloaded into memory_32_4_memory survive reset.
module memory_32_4_ram
   import memory_32_4_ram_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  mem_int            m,
   input  logic [DATA_W-1:0] m_wr_data,
   output logic [DATA_W-1:0] m_rd_data
);

   reg [DATA_W-1:0] memory_32_4_memory [0:DEPTH-1];

   // Writes ignore reset on purpose.
   always_ff @(posedge clk) begin
      if (m.wr_vld) begin
         memory_32_4_memory[m.wr_address] <= m_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m_rd_data <= '0;
      end else if (m.rd_vld) begin
         m_rd_data <= memory_32_4_memory[m.rd_address];
      end
   end

endmodule

// File: tb/tb_memory_32_4_ram.sv
// Scoreboard bench for memory_32_4_ram: expected read data is queued at drive time
// and compared one cycle later against m_rd_data.
module tb_memory_32_4_ram;
   import memory_32_4_ram_pkg::*;

   logic        clk;
   logic        reset;
   mem_int      m;
   logic [31:0] m_wr_data;
   logic [31:0] m_rd_data;

   int          checks;
   int          failures;
   logic [31:0] exp_q [$];
   logic [31:0] model_mem [0:15];
   logic [31:0] model_rd;

   memory_32_4_ram dut (
      .clk       (clk),
      .reset     (reset),
      .m         (m),
      .m_wr_data (m_wr_data),
      .m_rd_data (m_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   // One clock of stimulus; the reference model is read-first with reset over read.
   task automatic step(input logic r, input logic rv, input logic [3:0] ra,
                       input logic wv, input logic [3:0] wa, input logic [31:0] wd);
      logic [31:0] exp;
      @(negedge clk);
      reset        = r;
      m.rd_vld     = rv;
      m.rd_address = ra;
      m.wr_vld     = wv;
      m.wr_address = wa;
      m_wr_data    = wd;
      if (r)       exp = 32'd0;
      else if (rv) exp = model_mem[ra];
      else         exp = model_rd;
      exp_q.push_back(exp);
      model_rd = exp;
      if (wv) model_mem[wa] = wd;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL sb_empty actual=0 expected=1");
      end else begin
         check_eq("rd", m_rd_data, exp_q.pop_front());
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      model_rd  = 'x;
      for (int i = 0; i < 16; i++) model_mem[i] = 'x;
      reset     = 1'b1;
      m         = '0;
      m_wr_data = '0;

      // Reset: preload word 3 and write word 2 while reset is high; read in reset is dropped.
      step(1'b1, 1'b1, 4'd3, 1'b1, 4'd3, 32'hDEADBEEF);
      check_eq("rst_zero", m_rd_data, 32'd0);
      step(1'b1, 1'b1, 4'd3, 1'b1, 4'd2, 32'hCAFEF00D);
      check_eq("rst_drop_read", m_rd_data, 32'd0);
      step(1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 32'd0);
      check_eq("preload_kept", m_rd_data, 32'hDEADBEEF);
      step(1'b0, 1'b1, 4'd2, 1'b0, 4'd0, 32'd0);
      check_eq("wr_in_reset", m_rd_data, 32'hCAFEF00D);

      // Write then read, plus an independent read of another word in the write cycle.
      step(1'b0, 1'b1, 4'd3, 1'b1, 4'd5, 32'h12345678);
      check_eq("indep_rd", m_rd_data, 32'hDEADBEEF);
      step(1'b0, 1'b1, 4'd5, 1'b0, 4'd0, 32'd0);
      check_eq("wr_rd_5", m_rd_data, 32'h12345678);

      // Hold while rd_vld is low and the address moves.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'(i + 1), 1'b0, 4'd0, 32'd0);
      check_eq("hold", m_rd_data, 32'h12345678);

      // Same-address collision returns old data, new data on the next read.
      step(1'b0, 1'b0, 4'd0, 1'b1, 4'd7, 32'hAAAA0000);
      step(1'b0, 1'b1, 4'd7, 1'b1, 4'd7, 32'h5555FFFF);
      check_eq("collide_old", m_rd_data, 32'hAAAA0000);
      step(1'b0, 1'b1, 4'd7, 1'b0, 4'd0, 32'd0);
      check_eq("collide_new", m_rd_data, 32'h5555FFFF);

      // Full sweep, then back-to-back readback.
      for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 4'd0, 1'b1, 4'(i), 32'h101 * i);
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 4'(i), 1'b0, 4'd0, 32'd0);
         check_eq($sformatf("sweep_%0d", i), m_rd_data, 32'h101 * i);
      end

      // Reset clears read data but not contents.
      step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0);
      check_eq("rst_again", m_rd_data, 32'd0);
      step(1'b0, 1'b1, 4'd15, 1'b0, 4'd0, 32'd0);
      check_eq("after_rst_15", m_rd_data, 32'h0F0F);

      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL sb_leftover actual=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/memory_32_4_ram.md
Name: memory_32_4_ram

Overview:
- Simple dual-port synchronous RAM, 16 words x 32 bits, with one write port and one registered read port.
- Used as the per-lane tap/weight storage leaf inside the tap-memory wrappers. Six instances side by side form a 192-bit-wide tap memory.
- Addresses and valids arrive on a packed control struct. Write data and read data are separate 32-bit ports.
- Contents can be preloaded at simulation start through a hierarchical $readmemh into the storage array.

Parameters:
- DATA_W, 32, word width in bits. Implemented as a localparam; this block is fixed at 32.
- ADDR_W, 4, address width in bits. Localparam, fixed.
- DEPTH, 16, number of words (2**ADDR_W). Localparam.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- m  input  struct mem_int (10 bits)  control bundle with these fields:
  - rd_address [3:0]
  - rd_vld
  - wr_address [3:0]
  - wr_vld
- m_wr_data  input  32  write data, sampled with m.wr_vld
- m_rd_data  output  32  registered read data

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on reset. All state updates on posedge clk.
- Storage array:
  - Declared as reg [31:0] memory_32_4_memory [0:15].
  - This exact instance-internal name is mandatory; parent wrappers load it via $readmemh on <inst>.memory_32_4_memory.
  - No initial clear inside this block.
- Write:
  - On posedge clk with m.wr_vld=1, memory_32_4_memory[m.wr_address] <= m_wr_data.
  - When m.wr_vld=0, no write occurs.
  - Writes are also performed while reset is high. Reset never clears array contents, so preloaded taps survive reset.
- Read:
  - On posedge clk with m.rd_vld=1, m_rd_data <= memory_32_4_memory[m.rd_address].
  - Latency is exactly 1 cycle from rd_vld/rd_address to data.
  - When m.rd_vld=0, m_rd_data holds its previous value.
- Reset:
  - With reset=1 at posedge, m_rd_data <= 32'd0. Reset takes priority over a read in the same cycle.
  - A read requested in the reset cycle is dropped; data appears only for reads issued after reset deasserts.
- Read/write collision (same address, same cycle): read-first. m_rd_data returns the old contents; the new data is visible to a read one cycle later.
- Writes and reads at different addresses in the same cycle are fully independent.
- Address wrap: 4-bit addresses cover all 16 words, so there is no out-of-range case.
- There is no handshake or backpressure. Every valid is accepted in the cycle it is asserted.

Decomposition:
- Shared package/include (types.v, TYPES guard): the mem_int control struct typedefs for a 32-bit, 4-bit-address memory, with field order rd_address, rd_vld, wr_address, wr_vld.
  - The wrapper-specific aliases (mem_int_N_192_4) must be layout-identical to this struct.
- No sub-modules. This is a leaf; a single always block for write and one for read/reset is natural.

Test Plan:
1. Reset: preload word 3 = 32'hDEADBEEF via $readmemh, hold reset 2 cycles, then deassert. Read addr 3 -> m_rd_data = 0 during reset, 32'hDEADBEEF one cycle after the read. Contents preserved.
2. Write/read: write addr 5 = 32'h12345678, then next cycle rd_vld addr 5 -> 32'h12345678 appears exactly 1 cycle later.
3. Collision: addr 7 holds 32'hAAAA0000; in the same cycle write 32'h5555FFFF to addr 7 and read addr 7.
   - Read returns 32'hAAAA0000.
   - A re-read next cycle returns 32'h5555FFFF.
4. Hold: after reading 32'h12345678, drop rd_vld for 3 cycles while changing rd_address -> m_rd_data stays 32'h12345678.
5. Full sweep: write addr i = 32'h0000_0100*i + i for i=0..15, then read back 0..15 back-to-back -> each value one cycle after its address, with no wrap aliasing between addr 0 and 15.
6. Write during reset: assert reset, write addr 2 = 32'hCAFEF00D, deassert, read addr 2 -> 32'hCAFEF00D.
